vx_fetch_stage: RTL and testbench

Instruction-fetch stage sitting directly downstream of the warp scheduler and upstream of decode. It accepts one scheduled warp per cycle (wid, tmask, PC, uuid), issues a word-aligned instruction-cache read tagged by warp id, holds per-warp metadata in a tag table while the read is outstanding, and merges each cache response with its metadata into a buffered fetch output. At most one fetch per warp is in flight.

---
 rtl/vx_fetch_stage.sv | 172 +++++++++++++++++
 tb/tb_vx_fetch_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_fetch_stage.sv
// Instruction-fetch stage: takes one scheduled warp per cycle, issues a
// word-aligned icache read tagged by warp id, parks the warp metadata in a
// per-warp tag table, and merges each cache response with that metadata into
// a 2-entry output FIFO feeding decode.
//
// Handshakes: every channel uses valid/ready. A transfer ("fire") happens on a
// rising edge where valid && ready are both high. A producer holding valid
// keeps its payload stable until the transfer; ready may depend
// combinationally on registered state and on the consumer's own inputs, but
// valid never depends on the matching ready.
module vx_fetch_stage #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int UUID_WIDTH  = 44,
  parameter int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   sched_valid,
  output logic                   sched_ready,
  input  logic [NW_WIDTH-1:0]    sched_wid,
  input  logic [NUM_THREADS-1:0] sched_tmask,
  input  logic [XLEN-1:0]        sched_pc,
  input  logic [UUID_WIDTH-1:0]  sched_uuid,

  output logic                   icache_req_valid,
  input  logic                   icache_req_ready,
  output logic [XLEN-3:0]        icache_req_addr,
  output logic [NW_WIDTH-1:0]    icache_req_tag,

  input  logic                   icache_rsp_valid,
  output logic                   icache_rsp_ready,
  input  logic [31:0]            icache_rsp_data,
  input  logic [NW_WIDTH-1:0]    icache_rsp_tag,

  output logic                   fetch_valid,
  input  logic                   fetch_ready,
  output logic [NW_WIDTH-1:0]    fetch_wid,
  output logic [NUM_THREADS-1:0] fetch_tmask,
  output logic [XLEN-1:0]        fetch_pc,
  output logic [UUID_WIDTH-1:0]  fetch_uuid,
  output logic [31:0]            fetch_instr,

  output logic                   tag_err,
  output logic                   busy
);

  // Tag table: one pending bit plus metadata per warp
  logic [NUM_WARPS-1:0]   pending;
  logic [NUM_THREADS-1:0] tab_tmask [NUM_WARPS];
  logic [XLEN-1:0]        tab_pc    [NUM_WARPS];
  logic [UUID_WIDTH-1:0]  tab_uuid  [NUM_WARPS];

  // Single-entry request register
  logic                   req_valid;
  logic [XLEN-3:0]        req_addr;
  logic [NW_WIDTH-1:0]    req_tag;

  // Two-entry output FIFO
  logic [NW_WIDTH-1:0]    buf_wid   [2];
  logic [NUM_THREADS-1:0] buf_tmask [2];
  logic [XLEN-1:0]        buf_pc    [2];
  logic [UUID_WIDTH-1:0]  buf_uuid  [2];
  logic [31:0]            buf_instr [2];
  logic                   rd_ptr;
  logic                   wr_ptr;
  logic [1:0]             count;

  logic sched_fire;
  logic req_fire;
  logic rsp_fire;
  logic rsp_hit;
  logic push;
  logic pop;

  // A warp may be accepted only when it has nothing in flight and the request
  // register is free or draining this cycle. The pending check uses the
  // registered bit, so a response clearing it only helps from the next cycle.
  assign sched_ready = !pending[sched_wid] && (!req_valid || icache_req_ready);
  assign sched_fire  = sched_valid && sched_ready;
  assign req_fire    = req_valid && icache_req_ready;

  assign icache_rsp_ready = (count < 2'd2);
  assign rsp_fire         = icache_rsp_valid && icache_rsp_ready;
  assign rsp_hit          = pending[icache_rsp_tag];
  assign push             = rsp_fire && rsp_hit;

  assign icache_req_valid = req_valid;
  assign icache_req_addr  = req_addr;
  assign icache_req_tag   = req_tag;

  // Head entry is shown only while valid so idle outputs read as zero
  assign fetch_valid = (count != 2'd0);
  assign pop         = fetch_valid && fetch_ready;
  assign fetch_wid   = fetch_valid ? buf_wid[rd_ptr]   : '0;
  assign fetch_tmask = fetch_valid ? buf_tmask[rd_ptr] : '0;
  assign fetch_pc    = fetch_valid ? buf_pc[rd_ptr]    : '0;
  assign fetch_uuid  = fetch_valid ? buf_uuid[rd_ptr]  : '0;
  assign fetch_instr = fetch_valid ? buf_instr[rd_ptr] : '0;

  assign busy = req_valid || (|pending) || (count != 2'd0);

  // Pending bits and sticky tag error; set and clear never target one warp
  // in the same cycle because acceptance requires the bit to be clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= '0;
      tag_err <= 1'b0;
    end else begin
      if (rsp_fire) begin
        if (rsp_hit) pending[icache_rsp_tag] <= 1'b0;
        else         tag_err <= 1'b1;
      end
      if (sched_fire) pending[sched_wid] <= 1'b1;
    end
  end

  // Metadata capture on acceptance; guarded by the pending bit so no reset
  always_ff @(posedge clk) begin
    if (sched_fire) begin
      tab_tmask[sched_wid] <= sched_tmask;
      tab_pc[sched_wid]    <= sched_pc;
      tab_uuid[sched_wid]  <= sched_uuid;
    end
  end

  // Request register: load on acceptance, hold while stalled, clear on issue
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_tag   <= '0;
    end else if (sched_fire) begin
      req_valid <= 1'b1;
      req_addr  <= sched_pc[XLEN-1:2];
      req_tag   <= sched_wid;
    end else if (req_fire) begin
      req_valid <= 1'b0;
    end
  end

  // Output FIFO pointers and occupancy; push and pop together keep count
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Output FIFO storage: response data merged with the warp's metadata
  always_ff @(posedge clk) begin
    if (push) begin
      buf_wid[wr_ptr]   <= icache_rsp_tag;
      buf_tmask[wr_ptr] <= tab_tmask[icache_rsp_tag];
      buf_pc[wr_ptr]    <= tab_pc[icache_rsp_tag];
      buf_uuid[wr_ptr]  <= tab_uuid[icache_rsp_tag];
      buf_instr[wr_ptr] <= icache_rsp_data;
    end
  end

endmodule

// File: tb/tb_vx_fetch_stage.sv
// Bench for vx_fetch_stage: per-cycle vector table, directed corner-case
// sequences, then randomized traffic checked against a queue-based model.
module tb_vx_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        sched_valid;
  logic        sched_ready;
  logic [1:0]  sched_wid;
  logic [3:0]  sched_tmask;
  logic [31:0] sched_pc;
  logic [43:0] sched_uuid;
  logic        icache_req_valid;
  logic        icache_req_ready;
  logic [29:0] icache_req_addr;
  logic [1:0]  icache_req_tag;
  logic        icache_rsp_valid;
  logic        icache_rsp_ready;
  logic [31:0] icache_rsp_data;
  logic [1:0]  icache_rsp_tag;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [1:0]  fetch_wid;
  logic [3:0]  fetch_tmask;
  logic [31:0] fetch_pc;
  logic [43:0] fetch_uuid;
  logic [31:0] fetch_instr;
  logic        tag_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  vx_fetch_stage dut (
    .clk(clk), .reset(reset),
    .sched_valid(sched_valid), .sched_ready(sched_ready), .sched_wid(sched_wid),
    .sched_tmask(sched_tmask), .sched_pc(sched_pc), .sched_uuid(sched_uuid),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_addr(icache_req_addr), .icache_req_tag(icache_req_tag),
    .icache_rsp_valid(icache_rsp_valid), .icache_rsp_ready(icache_rsp_ready),
    .icache_rsp_data(icache_rsp_data), .icache_rsp_tag(icache_rsp_tag),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_wid(fetch_wid),
    .fetch_tmask(fetch_tmask), .fetch_pc(fetch_pc), .fetch_uuid(fetch_uuid),
    .fetch_instr(fetch_instr), .tag_err(tag_err), .busy(busy)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard types and reference-model state
  typedef struct packed {
    logic [1:0]  wid;
    logic [3:0]  tmask;
    logic [31:0] pc;
    logic [43:0] uuid;
    logic [31:0] instr;
  } fetch_t;
  typedef struct packed {
    logic [29:0] addr;
    logic [1:0]  tag;
  } req_t;

  fetch_t     exp_q[$];
  req_t       req_q[$];
  fetch_t     m_meta [4];
  logic [3:0] m_pend;
  logic [3:0] m_issued;
  logic       m_err;

  typedef struct {
    logic sv; logic [1:0] wid; logic [3:0] tmask; logic [31:0] pc; logic [43:0] uuid;
    logic rv; logic [1:0] rtag; logic [31:0] rdata;
    logic e_sr; logic e_rqv; logic [29:0] e_addr; logic [1:0] e_tag;
    logic e_fv; logic [1:0] e_fwid; logic [3:0] e_ftm; logic [31:0] e_fpc;
    logic [43:0] e_fuuid; logic [31:0] e_fins; logic e_busy;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(
    input logic sv, input logic [1:0] wid, input logic [3:0] tmask, input logic [31:0] pc,
    input logic [43:0] uuid, input logic rv, input logic [1:0] rtag, input logic [31:0] rdata,
    input logic e_sr, input logic e_rqv, input logic [29:0] e_addr, input logic [1:0] e_tag,
    input logic e_fv, input logic [1:0] e_fwid, input logic [3:0] e_ftm, input logic [31:0] e_fpc,
    input logic [43:0] e_fuuid, input logic [31:0] e_fins, input logic e_busy);
    vec_t v;
    v.sv = sv; v.wid = wid; v.tmask = tmask; v.pc = pc; v.uuid = uuid;
    v.rv = rv; v.rtag = rtag; v.rdata = rdata;
    v.e_sr = e_sr; v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_tag = e_tag;
    v.e_fv = e_fv; v.e_fwid = e_fwid; v.e_ftm = e_ftm; v.e_fpc = e_fpc;
    v.e_fuuid = e_fuuid; v.e_fins = e_fins; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv_sched(input logic v, input logic [1:0] w, input logic [31:0] pc,
                           input logic [43:0] u);
    sched_valid = v; sched_wid = w; sched_tmask = 4'b0001 << w; sched_pc = pc; sched_uuid = u;
  endtask

  task automatic drv_rsp(input logic v, input logic [1:0] t, input logic [31:0] d);
    icache_rsp_valid = v; icache_rsp_tag = t; icache_rsp_data = d;
  endtask

  task automatic chk_fetch(input string name, input logic [31:0] pc, input logic [31:0] ins);
    chk({name, "_fv"}, fetch_valid, 1'b1);
    chk({name, "_pc"}, fetch_pc, pc);
    chk({name, "_instr"}, fetch_instr, ins);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drv_sched(1'b0, 2'd0, 32'd0, 44'd0);
    drv_rsp(1'b0, 2'd0, 32'd0);
    icache_req_ready = 1'b1;
    fetch_ready = 1'b1;
    next(); next();
    reset = 1'b1;
    exp_q.delete(); req_q.delete();
    m_pend = '0; m_issued = '0; m_err = 1'b0;
  endtask

  // One randomized cycle checked against the behavioural model
  task automatic rand_cycle(input bit drain);
    int     cand[$];
    logic   e_sr, sf, rf, qf, ff;
    fetch_t e;
    for (int w = 0; w < 4; w++) if (m_issued[w]) cand.push_back(w);
    sched_valid = drain ? 1'b0 : 1'($urandom_range(0, 1));
    sched_wid = 2'($urandom_range(0, 3));
    sched_tmask = 4'($urandom);
    sched_pc = $urandom;
    sched_uuid = {12'($urandom), 32'($urandom)};
    icache_req_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    fetch_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    icache_rsp_valid = 1'b0;
    icache_rsp_tag = 2'($urandom_range(0, 3));
    icache_rsp_data = $urandom;
    if (cand.size() != 0 && (drain || $urandom_range(0, 1) == 1)) begin
      icache_rsp_valid = 1'b1;
      icache_rsp_tag = 2'(cand[$urandom_range(0, cand.size() - 1)]);
    end else if (!drain && $urandom_range(0, 31) == 0) begin
      icache_rsp_valid = 1'b1;
    end
    settle();
    e_sr = !m_pend[sched_wid] && (req_q.size() == 0 || icache_req_ready);
    chk("rnd_sched_ready", sched_ready, e_sr);
    chk("rnd_req_valid", icache_req_valid, req_q.size() != 0);
    if (req_q.size() != 0) begin
      chk("rnd_req_addr", icache_req_addr, req_q[0].addr);
      chk("rnd_req_tag", icache_req_tag, req_q[0].tag);
    end
    chk("rnd_rsp_ready", icache_rsp_ready, exp_q.size() < 2);
    chk("rnd_fetch_valid", fetch_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("rnd_fetch_wid", fetch_wid, exp_q[0].wid);
      chk("rnd_fetch_tmask", fetch_tmask, exp_q[0].tmask);
      chk("rnd_fetch_pc", fetch_pc, exp_q[0].pc);
      chk("rnd_fetch_uuid", fetch_uuid, exp_q[0].uuid);
      chk("rnd_fetch_instr", fetch_instr, exp_q[0].instr);
    end
    chk("rnd_tag_err", tag_err, m_err);
    chk("rnd_busy", busy, req_q.size() != 0 || m_pend != 0 || exp_q.size() != 0);
    sf = sched_valid && e_sr;
    rf = icache_rsp_valid && (exp_q.size() < 2);
    qf = (req_q.size() != 0) && icache_req_ready;
    ff = (exp_q.size() != 0) && fetch_ready;
    if (ff) void'(exp_q.pop_front());
    if (rf) begin
      if (m_pend[icache_rsp_tag]) begin
        e = m_meta[icache_rsp_tag];
        e.wid = icache_rsp_tag;
        e.instr = icache_rsp_data;
        exp_q.push_back(e);
        m_pend[icache_rsp_tag] = 1'b0;
        m_issued[icache_rsp_tag] = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (qf) begin
      m_issued[req_q[0].tag] = 1'b1;
      void'(req_q.pop_front());
    end
    if (sf) begin
      m_meta[sched_wid] = '{wid: sched_wid, tmask: sched_tmask, pc: sched_pc,
                            uuid: sched_uuid, instr: 32'd0};
      m_pend[sched_wid] = 1'b1;
      req_q.push_back('{addr: sched_pc[31:2], tag: sched_wid});
    end
    next();
  endtask

  initial begin
    // Reset state
    do_reset();
    reset = 1'b0;
    settle();
    chk("rst_sched_ready", sched_ready, 1'b1);
    chk("rst_rsp_ready", icache_rsp_ready, 1'b1);
    chk("rst_req_valid", icache_req_valid, 1'b0);
    chk("rst_req_addr", icache_req_addr, 30'd0);
    chk("rst_fetch_valid", fetch_valid, 1'b0);
    chk("rst_fetch_pc", fetch_pc, 32'd0);
    chk("rst_fetch_uuid", fetch_uuid, 44'd0);
    chk("rst_tag_err", tag_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    next();
    reset = 1'b1;

    // Vector table: single fetch, then out-of-order responses
    tbl.push_back(mk(1, 1, 4'b0001, 32'h80000010, 44'd5, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 30'h20000004, 1,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h13,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 4'b0001, 32'h80000010, 44'd5, 32'h13, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0001, 32'h100, 44'd10, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 4'b0010, 32'h200, 44'd11, 0, 0, 0,  1, 1, 30'h40, 0,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 2, 4'b0100, 32'h300, 44'd12, 0, 0, 0,  1, 1, 30'h80, 1,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  1, 1, 30'hC0, 2,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3, 0, 0, 0, 1, 2, 32'hA2,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3, 0, 0, 0, 1, 0, 32'hA0,  1, 0, 0, 0,  1, 2, 4'b0100, 32'h300, 44'd12, 32'hA2, 1));
    tbl.push_back(mk(0, 3, 0, 0, 0, 1, 1, 32'hA1,  1, 0, 0, 0,  1, 0, 4'b0001, 32'h100, 44'd10, 32'hA0, 1));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 4'b0010, 32'h200, 44'd11, 32'hA1, 1));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    icache_req_ready = 1'b1;
    fetch_ready = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      sched_valid = tbl[i].sv; sched_wid = tbl[i].wid; sched_tmask = tbl[i].tmask;
      sched_pc = tbl[i].pc; sched_uuid = tbl[i].uuid;
      drv_rsp(tbl[i].rv, tbl[i].rtag, tbl[i].rdata);
      settle();
      chk($sformatf("vec%0d_sched_ready", i), sched_ready, tbl[i].e_sr);
      chk($sformatf("vec%0d_req_valid", i), icache_req_valid, tbl[i].e_rqv);
      if (tbl[i].e_rqv) begin
        chk($sformatf("vec%0d_req_addr", i), icache_req_addr, tbl[i].e_addr);
        chk($sformatf("vec%0d_req_tag", i), icache_req_tag, tbl[i].e_tag);
      end
      chk($sformatf("vec%0d_fetch_valid", i), fetch_valid, tbl[i].e_fv);
      if (tbl[i].e_fv) begin
        chk($sformatf("vec%0d_fetch_wid", i), fetch_wid, tbl[i].e_fwid);
        chk($sformatf("vec%0d_fetch_tmask", i), fetch_tmask, tbl[i].e_ftm);
        chk($sformatf("vec%0d_fetch_pc", i), fetch_pc, tbl[i].e_fpc);
        chk($sformatf("vec%0d_fetch_uuid", i), fetch_uuid, tbl[i].e_fuuid);
        chk($sformatf("vec%0d_fetch_instr", i), fetch_instr, tbl[i].e_fins);
      end
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      next();
    end

    // Per-warp block: second wid-3 request waits for the tag-3 response
    drv_rsp(0, 0, 0);
    drv_sched(1, 3, 32'h400, 44'd20); settle();
    chk("blk_first_ready", sched_ready, 1'b1); next();
    drv_sched(1, 3, 32'h404, 44'd21); settle();
    chk("blk_held_a", sched_ready, 1'b0); next();
    settle(); chk("blk_held_b", sched_ready, 1'b0); next();
    drv_rsp(1, 3, 32'h33); settle();
    chk("blk_no_bypass", sched_ready, 1'b0); next();
    drv_rsp(0, 0, 0); settle();
    chk("blk_released", sched_ready, 1'b1);
    chk_fetch("blk_first", 32'h400, 32'h33); next();
    drv_sched(0, 0, 0, 0); settle();
    chk("blk_req_valid", icache_req_valid, 1'b1);
    chk("blk_req_addr", icache_req_addr, 30'h101); next();
    drv_rsp(1, 3, 32'h34); next();
    drv_rsp(0, 0, 0); settle();
    chk_fetch("blk_second", 32'h404, 32'h34); next();
    settle(); chk("blk_idle_busy", busy, 1'b0);

    // Backpressure: three responses against a stalled decode
    fetch_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      drv_sched(1, 2'(w), 32'h700 + 32'(4 * w), 44'(30 + w)); next();
    end
    drv_sched(0, 3, 0, 0); next(); next();
    drv_rsp(1, 0, 32'hB0); settle(); chk("bp_rdy0", icache_rsp_ready, 1'b1); next();
    drv_rsp(1, 1, 32'hB1); settle(); chk("bp_rdy1", icache_rsp_ready, 1'b1); next();
    drv_rsp(1, 2, 32'hB2); settle(); chk("bp_full_a", icache_rsp_ready, 1'b0); next();
    settle(); chk("bp_full_b", icache_rsp_ready, 1'b0);
    chk_fetch("bp_stable", 32'h700, 32'hB0); next();
    fetch_ready = 1'b1; settle();
    chk("bp_full_c", icache_rsp_ready, 1'b0);
    chk_fetch("bp_out0", 32'h700, 32'hB0); next();
    settle(); chk("bp_rdy2", icache_rsp_ready, 1'b1);
    chk_fetch("bp_out1", 32'h704, 32'hB1); next();
    drv_rsp(0, 0, 0); settle();
    chk_fetch("bp_out2", 32'h708, 32'hB2); next();
    settle(); chk("bp_drained_fv", fetch_valid, 1'b0); chk("bp_drained_busy", busy, 1'b0);

    // Cache stall: request held stable, new warps refused
    drv_sched(1, 0, 32'h500, 44'd40); settle(); chk("stall_acc", sched_ready, 1'b1); next();
    icache_req_ready = 1'b0;
    drv_sched(1, 1, 32'h600, 44'd41);
    for (int c = 0; c < 5; c++) begin
      settle();
      chk($sformatf("stall%0d_ready", c), sched_ready, 1'b0);
      chk($sformatf("stall%0d_addr", c), icache_req_addr, 30'h140);
      chk($sformatf("stall%0d_tag", c), icache_req_tag, 2'd0);
      next();
    end
    icache_req_ready = 1'b1; settle();
    chk("stall_rel_ready", sched_ready, 1'b1);
    chk("stall_rel_addr", icache_req_addr, 30'h140); next();
    drv_sched(0, 3, 0, 0); settle();
    chk("stall_next_addr", icache_req_addr, 30'h180);
    chk("stall_next_tag", icache_req_tag, 2'd1); next();
    drv_rsp(1, 0, 32'hC0); settle(); chk("stall_single_fire", icache_req_valid, 1'b0); next();
    drv_rsp(1, 1, 32'hC1); settle(); chk_fetch("stall_out0", 32'h500, 32'hC0); next();
    drv_rsp(0, 0, 0); settle(); chk_fetch("stall_out1", 32'h600, 32'hC1); next();

    // Bad tag, then reset with a fetch in flight
    drv_rsp(1, 2, 32'hDEAD); settle();
    chk("bad_rdy", icache_rsp_ready, 1'b1); chk("bad_err_before", tag_err, 1'b0); next();
    drv_rsp(0, 0, 0); settle();
    chk("bad_err", tag_err, 1'b1); chk("bad_dropped", fetch_valid, 1'b0); next();
    drv_sched(1, 1, 32'h900, 44'd50); next();
    drv_sched(0, 1, 0, 0); next();
    settle(); chk("mid_busy", busy, 1'b1);
    reset = 1'b0; next(); reset = 1'b1; settle();
    chk("rst2_ready", sched_ready, 1'b1);
    chk("rst2_err", tag_err, 1'b0);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_req_valid", icache_req_valid, 1'b0);
    chk("rst2_rsp_ready", icache_rsp_ready, 1'b1);
    drv_rsp(1, 1, 32'hEE); next();
    drv_rsp(0, 0, 0); settle();
    chk("stale_err", tag_err, 1'b1);
    chk("stale_dropped", fetch_valid, 1'b0);

    // Randomized traffic against the model, then drain
    do_reset();
    for (int n = 0; n < 600; n++) rand_cycle(1'b0);
    for (int n = 0; n < 40; n++) rand_cycle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
